// File: rtl/jpeg_tx_pkg.sv
// Shared constants and state encoding for the JPEG frame transmit scheduler.
package jpeg_tx_pkg;

    localparam logic [7:0] MRK_FF    = 8'hFF;
    localparam logic [7:0] MRK_SOI   = 8'hD8;
    localparam logic [7:0] MRK_EOI   = 8'hD9;
    localparam logic [7:0] MRK_STUFF = 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SOI0  = 3'd1,
        SOI1  = 3'd2,
        HDR   = 3'd3,
        DATA  = 3'd4,
        STUFF = 3'd5,
        EOI0  = 3'd6,
        EOI1  = 3'd7
    } tx_state_e;

endpackage

// File: rtl/jpeg_frame_tx_sched.sv
// Frames an entropy-coded byte stream as SOI + header ROM + stuffed data + EOI
// and feeds it byte-by-byte to a UART through a single registered output slot.
module jpeg_frame_tx_sched
    import jpeg_tx_pkg::*;
#(
    parameter int HDR_LEN = 607,
    parameter int CNT_W   = 16,
    localparam int AW     = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [AW-1:0]    hdr_addr,
    input  logic [7:0]       hdr_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic             abort,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [AW-1:0] HDR_LAST = AW'(HDR_LEN - 1);

    // Handshake: a byte moves on tx when tx_valid && tx_ready at a rising
    // edge; a stream byte is consumed when s_valid && s_ready at a rising edge.

    tx_state_e        state, state_d;
    logic [AW-1:0]    hdr_cnt, hdr_cnt_d;
    logic             to_eoi, to_eoi_d;
    logic             eoi_sent, eoi_sent_d;
    logic             done_d;
    logic [CNT_W-1:0] cnt_d;
    logic             load;
    logic [7:0]       load_byte;
    logic             slot_free;
    logic             s_ready_c;

    assign slot_free = !tx_valid || tx_ready;
    assign s_ready   = s_ready_c;
    assign hdr_addr  = hdr_cnt;
    assign busy      = (state != IDLE);

    always_comb begin
        state_d    = state;
        hdr_cnt_d  = hdr_cnt;
        to_eoi_d   = to_eoi;
        eoi_sent_d = eoi_sent;
        done_d     = 1'b0;
        cnt_d      = frame_cnt;
        load       = 1'b0;
        load_byte  = tx_data;
        s_ready_c  = 1'b0;
        case (state)
            IDLE: begin
                hdr_cnt_d  = '0;
                to_eoi_d   = 1'b0;
                eoi_sent_d = 1'b0;
                if (en && s_valid) state_d = SOI0;
            end
            SOI0: begin
                if (abort) begin
                    state_d = EOI0;
                end else if (slot_free) begin
                    load      = 1'b1;
                    load_byte = MRK_FF;
                    state_d   = SOI1;
                end
            end
            SOI1: begin
                if (abort) begin
                    state_d = EOI0;
                end else if (slot_free) begin
                    load      = 1'b1;
                    load_byte = MRK_SOI;
                    hdr_cnt_d = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (abort) begin
                    state_d = EOI0;
                end else if (slot_free) begin
                    load      = 1'b1;
                    load_byte = hdr_data;
                    if (hdr_cnt == HDR_LAST) begin
                        hdr_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        hdr_cnt_d = hdr_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (abort) begin
                    state_d = EOI0;
                end else begin
                    s_ready_c = slot_free;
                    if (s_valid && slot_free) begin
                        load      = 1'b1;
                        load_byte = s_data;
                        // A 0xFF data byte must be followed by 0x00 before anything else.
                        if (s_data == MRK_FF) begin
                            state_d  = STUFF;
                            to_eoi_d = s_last;
                        end else if (s_last) begin
                            state_d = EOI0;
                        end
                    end
                end
            end
            STUFF: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = MRK_STUFF;
                    state_d   = (to_eoi || abort) ? EOI0 : DATA;
                end else if (abort) begin
                    to_eoi_d = 1'b1;
                end
            end
            EOI0: begin
                eoi_sent_d = 1'b0;
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = MRK_FF;
                    state_d   = EOI1;
                end
            end
            EOI1: begin
                // Stay here until the UART has actually taken the 0xD9.
                if (!eoi_sent) begin
                    if (slot_free) begin
                        load       = 1'b1;
                        load_byte  = MRK_EOI;
                        eoi_sent_d = 1'b1;
                    end
                end else if (tx_ready) begin
                    done_d  = 1'b1;
                    cnt_d   = frame_cnt + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr_cnt    <= '0;
            to_eoi     <= 1'b0;
            eoi_sent   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state      <= state_d;
            hdr_cnt    <= hdr_cnt_d;
            to_eoi     <= to_eoi_d;
            eoi_sent   <= eoi_sent_d;
            frame_done <= done_d;
            frame_cnt  <= cnt_d;
            if (load) begin
                tx_valid <= 1'b1;
                tx_data  <= load_byte;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_frame_tx_sched.sv
// Directed bench for jpeg_frame_tx_sched: expected tx bytes queued by the
// stimulus, popped and compared by a monitor on every accepted tx byte.
module tb_jpeg_frame_tx_sched;

    localparam int HDR_LEN = 4;
    localparam int CNT_W   = 16;
    localparam int AW      = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [AW-1:0]    hdr_addr;
    logic [7:0]       hdr_data;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             abort;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] frame_cnt;

    logic [7:0] rom [HDR_LEN];
    assign hdr_data = rom[hdr_addr];

    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         done_pulses = 0;
    bit         rdy_rand = 1'b0;
    bit         stall_pend = 1'b0;
    logic [7:0] held;

    jpeg_frame_tx_sched #(.HDR_LEN(HDR_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .hdr_addr(hdr_addr), .hdr_data(hdr_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .abort(abort), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Clock and UART ready generation (ready changes just after the rising edge).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        tx_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_pend) begin
                n_tests++;
                if (!tx_valid || tx_data !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, held);
                end
            end
            stall_pend = tx_valid && !tx_ready;
            held       = tx_data;
            if (tx_valid && tx_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_byte: got unexpected %02h, queue empty", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %02h, required %02h", tx_data, e);
                    end
                end
            end
            if (frame_done) done_pulses++;
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_hdr();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD8);
        for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(rom[i]);
    endtask

    task automatic push_eoi();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
    endtask

    // Driver: present one stream byte and hold it until it is consumed.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int k;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        k = 0;
        while (!s_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic end_stream();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!frame_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) check("frame_done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        abort = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_hdr_addr", hdr_addr, 0);
        rst_n = 1'b1;

        // en low keeps the block idle even with data waiting.
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h55;
        repeat (8) @(negedge clk);
        check("en_low_tx_valid", tx_valid, 0);
        check("en_low_s_ready", s_ready, 0);
        check("en_low_busy", busy, 0);
        s_valid = 1'b0;

        // Basic frame.
        en = 1'b1;
        done_pulses = 0;
        push_hdr();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        push_eoi();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        end_stream();
        wait_done(200);
        check("basic_done_pulses", done_pulses, 1);
        check("basic_frame_cnt", frame_cnt, 1);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_busy", busy, 0);

        // Stuffing with a randomly stalling UART.
        rdy_rand = 1'b1;
        push_hdr();
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        push_eoi();
        send_byte(8'hFF, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'hFF, 1'b1);
        end_stream();
        wait_done(3000);
        rdy_rand = 1'b0;
        repeat (3) @(negedge clk);
        check("stuff_frame_cnt", frame_cnt, 2);
        check("stuff_queue_empty", exp_q.size(), 0);

        // Abort right after a 0xFF data byte: stuff byte, then EOI.
        push_hdr();
        exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        push_eoi();
        send_byte(8'h01, 1'b0);
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        s_data = 8'h33; s_valid = 1'b1; s_last = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; en = 1'b0;
        check("abort_s_ready_0", s_ready, 0);
        @(negedge clk);
        check("abort_s_ready_1", s_ready, 0);
        @(negedge clk);
        check("abort_s_ready_2", s_ready, 0);
        s_valid = 1'b0;
        wait_done(200);
        check("abort_frame_cnt", frame_cnt, 3);
        check("abort_queue_empty", exp_q.size(), 0);

        // Reset while the header is being sent.
        en = 1'b1;
        push_hdr();
        exp_q.push_back(8'h77);
        push_eoi();
        begin
            int k;
            @(negedge clk);
            s_data = 8'h77; s_valid = 1'b1; s_last = 1'b1;
            k = 0;
            while (!(busy && hdr_addr == 2'd1) && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) check("hdr_reach_timeout", 32'd0, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", tx_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        push_hdr();
        exp_q.push_back(8'h5A);
        push_eoi();
        send_byte(8'h5A, 1'b1);
        end_stream();
        wait_done(200);
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
